// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the arbiter-to-Wishbone memory bridge.
// Holds the bridge FSM state type, the read-abort data word and the
// default acknowledge timeout used when WB_TIMEOUT_EN is defined.
package wb_bridge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wb_state_t;

  // Returned as read data when a read is aborted for lack of ACK.
  localparam logic [31:0] WB_ABORT_DATA = 32'hDEADBEEF;

  // Default number of REQ cycles without ACK before the cycle is aborted.
  localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd1023;

  // Wishbone byte-lane select width.
  localparam int SEL_W = 4;

endpackage

// File: rtl/wb_timeout_ctr.sv
// ACK timeout counter for the Wishbone bridge (only built with WB_TIMEOUT_EN).
// The count is held at zero while clear_i is high and advances once per cycle
// while enable_i is high. expired_o flags the cycle in which this increment
// would make the count reach LIMIT, so the owner aborts after exactly LIMIT
// consecutive cycles without ACK.
module wb_timeout_ctr
  import wb_bridge_pkg::*;
#(
  parameter logic [15:0] LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Widened compare so a count at the top of the range cannot wrap.
  assign expired_o = enable_i && (({1'b0, cnt_q} + 17'd1) >= {1'b0, LIMIT});

endmodule

// File: rtl/wb_mem_bridge.sv
// Memory-side bridge behind the CPU/VGA arbiter. Each single-cycle
// mem_read/mem_write strobe becomes one classic Wishbone B4 master cycle;
// mem_busy stays high until the slave acknowledges, and read data is
// returned on data_from_mem. All outputs are registered.
// Optional build macro WB_TIMEOUT_EN: abort a cycle after TIMEOUT_CYC
// cycles without ACK, return WB_ABORT_DATA on reads and set the sticky
// timeout_err flag. Without the macro the bridge waits for ACK forever.
module wb_mem_bridge
  import wb_bridge_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] adr_to_mem,
  input  logic [DATA_W-1:0] data_to_mem,
  input  logic [SEL_W-1:0]  sel_to_mem,
  output logic              mem_busy,
  output logic [DATA_W-1:0] data_from_mem,
  output logic              WB_CYC_O,
  output logic              WB_STB_O,
  output logic              WB_WE_O,
  output logic [ADDR_W-1:0] WB_ADR_O,
  output logic [DATA_W-1:0] WB_DAT_O,
  output logic [SEL_W-1:0]  WB_SEL_O,
  input  logic [DATA_W-1:0] WB_DAT_I,
  input  logic              WB_ACK_I,
  output logic              timeout_err
);

  wb_state_t         state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              terr_q, terr_d;
  logic              tmo_expired;

`ifdef WB_TIMEOUT_EN
  // Held clear while idle, so every REQ visit starts counting from zero.
  wb_timeout_ctr #(
    .LIMIT     (TIMEOUT_CYC)
  ) u_tmo (
    .clk       (clk),
    .nRst      (nRst),
    .clear_i   (state_q == IDLE),
    .enable_i  ((state_q == REQ) && !WB_ACK_I),
    .expired_o (tmo_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign tmo_expired        = 1'b0;
`endif

  // Next-state and registered-output logic of the IDLE/REQ bus FSM.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    rdata_d = rdata_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          // A write wins over a simultaneous read; the read is dropped.
          state_d = REQ;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = mem_write;
          adr_d   = adr_to_mem;
          dat_d   = data_to_mem;
          sel_d   = sel_to_mem;
          busy_d  = 1'b1;
        end else begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          adr_d   = '0;
          dat_d   = '0;
          sel_d   = '0;
          busy_d  = 1'b0;
        end
      end
      REQ: begin
        if (WB_ACK_I || tmo_expired) begin
          // ACK takes precedence over a timeout expiring in the same cycle.
          state_d = IDLE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          adr_d   = '0;
          dat_d   = '0;
          sel_d   = '0;
          busy_d  = 1'b0;
          if (WB_ACK_I) begin
            if (!we_q) begin
              rdata_d = WB_DAT_I;
            end
          end else begin
            if (!we_q) begin
              rdata_d = DATA_W'(WB_ABORT_DATA);
            end
            terr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      terr_q  <= terr_d;
    end
  end

  assign WB_CYC_O      = cyc_q;
  assign WB_STB_O      = stb_q;
  assign WB_WE_O       = we_q;
  assign WB_ADR_O      = adr_q;
  assign WB_DAT_O      = dat_q;
  assign WB_SEL_O      = sel_q;
  assign mem_busy      = busy_q;
  assign data_from_mem = rdata_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_wb_mem_bridge.sv
// Scoreboard bench for wb_mem_bridge: an arbiter-style driver issues
// requests and pushes expected bus cycles and responses, a Wishbone slave
// model with programmable wait states serves them, and a monitor compares
// the DUT outputs against the queued expectations.
module tb_wb_mem_bridge;

  localparam logic [15:0] TMO = 16'd8;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] adr_to_mem = '0;
  logic [31:0] data_to_mem = '0;
  logic [3:0]  sel_to_mem = '0;
  logic        mem_busy;
  logic [31:0] data_from_mem;
  logic        WB_CYC_O, WB_STB_O, WB_WE_O;
  logic [31:0] WB_ADR_O, WB_DAT_O;
  logic [3:0]  WB_SEL_O;
  logic [31:0] WB_DAT_I = '0;
  logic        WB_ACK_I = 1'b0;
  logic        timeout_err;

  wb_mem_bridge #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .nRst(nRst),
    .mem_read(mem_read), .mem_write(mem_write),
    .adr_to_mem(adr_to_mem), .data_to_mem(data_to_mem), .sel_to_mem(sel_to_mem),
    .mem_busy(mem_busy), .data_from_mem(data_from_mem),
    .WB_CYC_O(WB_CYC_O), .WB_STB_O(WB_STB_O), .WB_WE_O(WB_WE_O),
    .WB_ADR_O(WB_ADR_O), .WB_DAT_O(WB_DAT_O), .WB_SEL_O(WB_SEL_O),
    .WB_DAT_I(WB_DAT_I), .WB_ACK_I(WB_ACK_I),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } bus_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int passes = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];
  logic [31:0] last_read = '0;
  logic [31:0] exp_hold = '0;
  logic        exp_terr = 1'b0;
  int          next_waits = 0;
  int          noise_mode = 0;
  bit          mon_en = 1'b0;
  bit          b2b_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Wishbone slave: ACK after next_waits wait states; random ACK noise while idle.
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (!nRst) begin
      WB_ACK_I = 1'b0;
      wcnt = 0;
    end else if (WB_CYC_O && WB_STB_O) begin
      if (wcnt >= next_waits) begin
        WB_ACK_I = 1'b1;
        WB_DAT_I = slv_mem[WB_ADR_O[5:2]];
        if (WB_WE_O) begin
          for (int b = 0; b < 4; b++)
            if (WB_SEL_O[b]) slv_mem[WB_ADR_O[5:2]][8*b +: 8] = WB_DAT_O[8*b +: 8];
        end
        wcnt = 0;
      end else begin
        WB_ACK_I = 1'b0;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      WB_ACK_I = (noise_mode == 2) || ((noise_mode == 1) && ($urandom_range(0, 3) == 0));
      WB_DAT_I = $urandom;
    end
  end

  // Monitor: compare bus cycles and responses with the scoreboard queues.
  bit   prev_cyc = 1'b0, prev_busy = 1'b0, have_exp = 1'b0;
  int   gap = 0, busy_cnt = 0;
  bus_t cur_exp;
  rsp_t r;
  always @(negedge clk) begin
    if (!nRst) begin
      prev_cyc = 1'b0; prev_busy = 1'b0; have_exp = 1'b0; gap = 0; busy_cnt = 0;
    end else begin
      if (WB_CYC_O && !prev_cyc) begin
        if (mon_en) begin
          if (b2b_mode) chk("b2b_idle_gap", gap, 1);
          chk("bus_cycle_expected", bus_q.size() != 0, 1'b1);
          have_exp = (bus_q.size() != 0);
          if (have_exp) cur_exp = bus_q.pop_front();
        end
        gap = 0;
      end else if (!WB_CYC_O) begin
        gap++;
      end
      if (mon_en) begin
        if (WB_CYC_O && have_exp) begin
          chk("bus_stb", WB_STB_O, 1'b1);
          chk("bus_we",  WB_WE_O, cur_exp.we);
          chk("bus_adr", WB_ADR_O, cur_exp.adr);
          chk("bus_dat", WB_DAT_O, cur_exp.dat);
          chk("bus_sel", WB_SEL_O, cur_exp.sel);
        end else if (!WB_CYC_O) begin
          chk("idle_stb_we", {WB_STB_O, WB_WE_O}, 2'b00);
        end
      end
      if (mem_busy) begin
        busy_cnt++;
      end else begin
        if (prev_busy && mon_en) begin
          chk("rsp_expected", rsp_q.size() != 0, 1'b1);
          if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            chk("rsp_data", data_from_mem, r.data);
            chk("rsp_busy_cycles", busy_cnt, r.cyc);
            exp_hold = r.data;
          end
        end else if (mon_en) begin
          chk("data_hold", data_from_mem, exp_hold);
        end
        busy_cnt = 0;
      end
      if (mon_en) chk("timeout_err", timeout_err, exp_terr);
      prev_cyc = WB_CYC_O;
      prev_busy = mem_busy;
    end
  end

  // Arbiter-side request: update the reference model, queue expectations, strobe, wait.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input int waits, input bit abort);
    bus_t b;
    rsp_t e;
    int   n;
    b.we = wr; b.adr = adr; b.dat = dat; b.sel = sel;
    if (wr)         e.data = last_read;
    else if (abort) e.data = 32'hDEADBEEF;
    else            e.data = ref_mem[adr[5:2]];
    e.cyc = abort ? int'(TMO) : waits + 1;
    if (!wr) last_read = e.data;
    if (wr && !abort) begin
      for (int k = 0; k < 4; k++)
        if (sel[k]) ref_mem[adr[5:2]][8*k +: 8] = dat[8*k +: 8];
    end
    bus_q.push_back(b);
    rsp_q.push_back(e);
    next_waits = waits;
    mem_read = rd; mem_write = wr;
    adr_to_mem = adr; data_to_mem = dat; sel_to_mem = sel;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    n = 0;
    while (mem_busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_released", mem_busy, 1'b0);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      slv_mem[i] = v;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc",  WB_CYC_O, 1'b0);
    chk("rst_stb",  WB_STB_O, 1'b0);
    chk("rst_we",   WB_WE_O, 1'b0);
    chk("rst_adr",  WB_ADR_O, 32'h0);
    chk("rst_dat",  WB_DAT_O, 32'h0);
    chk("rst_sel",  WB_SEL_O, 4'h0);
    chk("rst_busy", mem_busy, 1'b0);
    chk("rst_rdat", data_from_mem, 32'h0);
    chk("rst_terr", timeout_err, 1'b0);
    @(negedge clk); nRst = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    noise_mode = 1;

    // Read with zero wait states.
    ref_mem[3] = 32'h1234_5678; slv_mem[3] = 32'h1234_5678;
    issue(1'b1, 1'b0, 32'h0000_000C, $urandom, 4'hF, 0, 1'b0);
    // Write with three wait states and partial byte select, then read it back.
    issue(1'b0, 1'b1, 32'h3300_0010, 32'hCAFE_F00D, 4'b0011, 3, 1'b0);
    issue(1'b1, 1'b0, 32'h3300_0010, 32'h0, 4'hF, 2, 1'b0);
    // Read and write together: the write wins.
    issue(1'b1, 1'b1, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), 1, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic rd, wr;
      wr = $urandom_range(0, 1);
      rd = !wr || ($urandom_range(0, 3) == 0);
      issue(rd, wr, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
            $urandom_range(0, 3), 1'b0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Ten back-to-back reads with ACK held high.
    noise_mode = 2;
    for (int t = 0; t < 10; t++) begin
      issue(1'b1, 1'b0, $urandom & 32'hFFFF_FFFC, 32'h0, 4'hF, 0, 1'b0);
      b2b_mode = 1'b1;
    end
    b2b_mode = 1'b0;
    noise_mode = 1;
    @(posedge clk); #1;

    // Reset pulsed in the middle of a read.
    mon_en = 1'b0;
    noise_mode = 0;
    next_waits = 5;
    mem_read = 1'b1; adr_to_mem = 32'h0000_0020; sel_to_mem = 4'hF;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", mem_busy, 1'b1);
    chk("pre_rst_cyc", WB_CYC_O, 1'b1);
    #2 nRst = 1'b0;
    #1;
    chk("async_rst_cyc",  WB_CYC_O, 1'b0);
    chk("async_rst_stb",  WB_STB_O, 1'b0);
    chk("async_rst_busy", mem_busy, 1'b0);
    chk("async_rst_rdat", data_from_mem, 32'h0);
    @(posedge clk); #1;
    nRst = 1'b1;
    last_read = '0;
    exp_hold = '0;
    noise_mode = 2;
    repeat (3) begin
      @(posedge clk); #1;
      chk("late_ack_busy", mem_busy, 1'b0);
      chk("late_ack_cyc", WB_CYC_O, 1'b0);
    end
    noise_mode = 1;
    mon_en = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_0024, 32'h0, 4'hF, 1, 1'b0);

`ifdef WB_TIMEOUT_EN
    // Read that is never acknowledged: aborts after TMO cycles.
    issue(1'b1, 1'b0, 32'h0000_0028, 32'h0, 4'hF, 1000, 1'b1);
    exp_terr = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_002C, 32'h0, 4'hF, 1, 1'b0);
`endif

    repeat (3) begin @(posedge clk); #1; end
    chk("bus_q_drained", bus_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
